// File: rtl/rom_seq_pkg.sv
// Shared state encoding and end-of-program marker for rom_sequencer.
package rom_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE_A,
        ISSUE_B,
        DONE,
        ERR
    } seq_state_t;

    // All-ones end marker; users slice it down to their ROM word width.
    localparam logic [63:0] END_WORD = '1;

endpackage

// File: rtl/rom_sequencer.sv
// Walks a dual-port instruction ROM two words per fetch and issues each word as a command.
// Optional macro ROM_SEQ_LOOP_EN: program end restarts from address 0 instead of stopping.
module rom_sequencer
    import rom_seq_pkg::*;
#(
    parameter int unsigned ADDR_ROM_SZ = 4,
    parameter int unsigned DATA_ROM_SZ = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   I_START,
    input  logic                   I_STOP,
    output logic [ADDR_ROM_SZ-1:0] O_ADDR_ROM_A,
    output logic [ADDR_ROM_SZ-1:0] O_ADDR_ROM_B,
    input  logic [DATA_ROM_SZ-1:0] I_DATA_ROM_A,
    input  logic [DATA_ROM_SZ-1:0] I_DATA_ROM_B,
    input  logic [ADDR_ROM_SZ-1:0] I_ADDR_ROM_A,
    input  logic [ADDR_ROM_SZ-1:0] I_ADDR_ROM_B,
    output logic [DATA_ROM_SZ-1:0] O_CMD,
    output logic                   O_CMD_VALID,
    input  logic                   I_CMD_READY,
    output logic                   O_BUSY,
    output logic                   O_DONE,
    output logic                   O_ERR
);

    localparam logic [DATA_ROM_SZ-1:0] END_W   = END_WORD[DATA_ROM_SZ-1:0];
    localparam logic [ADDR_ROM_SZ-1:0] LAST_PC = {{(ADDR_ROM_SZ-1){1'b1}}, 1'b0};
    localparam logic [ADDR_ROM_SZ-1:0] PC_STEP = ADDR_ROM_SZ'(2);

    seq_state_t             state, state_next;
    seq_state_t             end_state;
    logic [ADDR_ROM_SZ-1:0] pc, pc_next, end_pc;
    logic [DATA_ROM_SZ-1:0] cmd_next;
    logic                   valid_next, done_next, err_next;
    logic                   echo_bad;

`ifdef ROM_SEQ_LOOP_EN
    assign end_state = FETCH;
    assign end_pc    = '0;
`else
    assign end_state = DONE;
    assign end_pc    = pc;
`endif

    // pc is always even, so the B address is pc with bit 0 set.
    assign O_ADDR_ROM_A = pc;
    assign O_ADDR_ROM_B = {pc[ADDR_ROM_SZ-1:1], 1'b1};

    assign echo_bad = (I_ADDR_ROM_A != O_ADDR_ROM_A) || (I_ADDR_ROM_B != O_ADDR_ROM_B);

    assign O_BUSY = (state == FETCH) || (state == ISSUE_A) ||
                    (state == ISSUE_B) || (state == DONE);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        cmd_next   = O_CMD;
        valid_next = O_CMD_VALID;
        done_next  = 1'b0;
        err_next   = O_ERR;

        if (I_STOP) begin
            state_next = IDLE;
            valid_next = 1'b0;
            err_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (I_START) begin
                        pc_next    = '0;
                        state_next = FETCH;
                    end
                end
                ERR: begin
                    err_next = 1'b1;
                    if (I_START) begin
                        err_next   = 1'b0;
                        pc_next    = '0;
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    state_next = ISSUE_A;
                end
                // First cycle of ISSUE_A (valid low) is the ROM-data-valid cycle.
                ISSUE_A: begin
                    if (!O_CMD_VALID) begin
                        if (echo_bad) begin
                            state_next = ERR;
                            err_next   = 1'b1;
                        end else if (I_DATA_ROM_A == END_W) begin
                            state_next = end_state;
                            pc_next    = end_pc;
                            done_next  = 1'b1;
                        end else begin
                            cmd_next   = I_DATA_ROM_A;
                            valid_next = 1'b1;
                        end
                    end else if (I_CMD_READY) begin
                        valid_next = 1'b0;
                        state_next = ISSUE_B;
                    end
                end
                ISSUE_B: begin
                    if (!O_CMD_VALID) begin
                        if (I_DATA_ROM_B == END_W) begin
                            state_next = end_state;
                            pc_next    = end_pc;
                            done_next  = 1'b1;
                        end else begin
                            cmd_next   = I_DATA_ROM_B;
                            valid_next = 1'b1;
                        end
                    end else if (I_CMD_READY) begin
                        valid_next = 1'b0;
                        if (pc == LAST_PC) begin
                            state_next = end_state;
                            pc_next    = end_pc;
                            done_next  = 1'b1;
                        end else begin
                            pc_next    = pc + PC_STEP;
                            state_next = FETCH;
                        end
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            pc          <= '0;
            O_CMD       <= '0;
            O_CMD_VALID <= 1'b0;
            O_DONE      <= 1'b0;
            O_ERR       <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            O_CMD       <= cmd_next;
            O_CMD_VALID <= valid_next;
            O_DONE      <= done_next;
            O_ERR       <= err_next;
        end
    end

endmodule

// File: doc/rom_sequencer.md
ROM_SEQUENCER -- requirements
Module: rom_sequencer

Interface
REQ-001 The block SHALL have the following parameters:
- ADDR_ROM_SZ, default 4, instruction ROM address width.
- DATA_ROM_SZ, default 16, instruction ROM word width.
REQ-002 The block SHALL have the following ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock 50 MHz.
- RST_N  in  1  asynchronous active-low reset.
- I_START  in  1  start program; sampled in IDLE/ERR only.
- I_STOP  in  1  abort; highest priority after reset.
- O_ADDR_ROM_A  out  ADDR_ROM_SZ  word A address to ROM (always even).
- O_ADDR_ROM_B  out  ADDR_ROM_SZ  word B address to ROM (= A+1).
- I_DATA_ROM_A  in  DATA_ROM_SZ  word A from ROM, 1-cycle registered latency.
- I_DATA_ROM_B  in  DATA_ROM_SZ  word B from ROM.
- I_ADDR_ROM_A  in  ADDR_ROM_SZ  address echoed by ROM with word A.
- I_ADDR_ROM_B  in  ADDR_ROM_SZ  address echoed by ROM with word B.
- O_CMD  out  DATA_ROM_SZ  command word to downstream I2C command consumer.
- O_CMD_VALID  out  1  O_CMD valid.
- I_CMD_READY  in  1  consumer accepts O_CMD.
- O_BUSY  out  1  program running (not IDLE/ERR).
- O_DONE  out  1  one-cycle pulse at program end.
- O_ERR  out  1  address-echo mismatch; sticky.

Function
REQ-003 The FSM SHALL have the states IDLE, FETCH, ISSUE_A, ISSUE_B, DONE and ERR, with a registered program counter pc that is always even.
REQ-004 O_ADDR_ROM_A SHALL equal pc and O_ADDR_ROM_B SHALL equal pc+1, both registered and held stable in every state.
REQ-005 In IDLE, I_START=1 SHALL set pc=0 and move to FETCH.
REQ-006 FETCH SHALL last exactly one cycle and then move to ISSUE_A, so that ROM data is valid on entry to ISSUE_A; first O_CMD_VALID SHALL rise 2 cycles after I_START is sampled.
REQ-007 On entry to ISSUE_A, if I_ADDR_ROM_A!=pc or I_ADDR_ROM_B!=pc+1, the block SHALL go to ERR and set O_ERR=1, and no command SHALL be issued.
REQ-008 In ISSUE_A, if I_DATA_ROM_A equals END_WORD (all ones), the block SHALL end the program (REQ-011); otherwise it SHALL drive O_CMD=I_DATA_ROM_A with O_CMD_VALID=1 until I_CMD_READY=1, then move to ISSUE_B.
REQ-009 ISSUE_B SHALL behave as ISSUE_A using word B: END_WORD ends the program; otherwise the block SHALL issue the word, and on acceptance either set pc=pc+2 and move to FETCH, or end the program if pc==2**ADDR_ROM_SZ-2 (address wrap).
REQ-010 While O_CMD_VALID=1, O_CMD SHALL NOT change until accepted; an END_WORD SHALL never be presented with O_CMD_VALID=1.
REQ-011 Program end SHALL move the FSM to DONE, which pulses O_DONE=1 for one cycle and then moves to IDLE.
REQ-012 I_START while busy SHALL be ignored.
REQ-013 I_STOP=1 in any state SHALL return the FSM to IDLE next cycle with O_CMD_VALID=0, no O_DONE pulse, and O_ERR cleared.
REQ-014 In ERR, O_ERR SHALL be held at 1; I_START SHALL clear O_ERR and restart as from IDLE.
REQ-015 O_BUSY SHALL be 1 in FETCH, ISSUE_A, ISSUE_B and DONE.

Reset
REQ-016 RST_N=0 SHALL asynchronously force state=IDLE, pc=0, O_ADDR_ROM_A=0, O_ADDR_ROM_B=1, O_CMD=0, O_CMD_VALID=0, O_BUSY=0, O_DONE=0 and O_ERR=0.
REQ-017 Reset asserted mid-transaction SHALL drop O_CMD_VALID without requiring I_CMD_READY.

Configuration
REQ-018 With macro ROM_SEQ_LOOP_EN defined, program end (END_WORD or address wrap) SHALL instead pulse O_DONE for one cycle, set pc=0 and go to FETCH, looping until I_STOP=1.
REQ-019 Without ROM_SEQ_LOOP_EN, program end SHALL go to DONE and then IDLE.

Structure
REQ-020 The package rom_seq_pkg SHALL hold the state enum and the END_WORD constant, the latter derived from DATA_ROM_SZ as all ones.
REQ-021 The block SHALL be a single module with no sub-module; the bench SHALL pair it with the team's dual-port registered instruction ROM.

Verification
REQ-022 Start with ROM contents {0x1001,0x1002,0xFFFF,...} and I_CMD_READY=1 -> O_CMD 0x1001 then 0x1002, O_DONE at ISSUE_A of pc=2, O_ERR=0.
REQ-023 I_CMD_READY held 0 for 5 cycles on the first command -> O_CMD stable at 0x1001 with O_CMD_VALID=1 throughout, and the address outputs unchanged.
REQ-024 ROM filled with 16 non-END words, ADDR_ROM_SZ=4 -> 16 commands in address order, then DONE after pc=14; with ROM_SEQ_LOOP_EN, word 0 is reissued after the O_DONE pulse.
REQ-025 Force I_ADDR_ROM_B=3 while pc=0 -> ERR, O_ERR=1 with no command issued; I_START then clears O_ERR and restarts.
REQ-026 I_STOP pulse in ISSUE_B, then RST_N pulse mid-FETCH -> IDLE, O_CMD_VALID=0, no O_DONE, and all outputs at their reset values.
